riscv_boot_ctrl: RTL and testbench
==================================

RISCV_BOOT_CTRL -- requirements
Module: riscv_boot_ctrl

Interface
REQ-001 Parameter IMEM_DEPTH, default 256, instruction memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 8, imem word-address width; IMEM_DEPTH SHALL NOT exceed 2**ADDR_W.
REQ-003 clk  input  1  single clock for all state, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load/run session.
REQ-006 load_len  input  ADDR_W+1  payload word count, sampled when start is accepted.
REQ-007 cycle_limit  input  32  maximum RUN cycles; 0 = unlimited; sampled when start is accepted.
REQ-008 s_valid / s_data  input  1 / 32  program word stream.
REQ-009 s_ready  output  1  stream ready.
REQ-010 imem_we / imem_addr / imem_wdata  output  1 / ADDR_W / 32  instruction memory write port.
REQ-011 core_rst  output  1  reset to the RISCV_32 core, active-high.
REQ-012 core_instr  input  32  instruction currently fetched by the core.
REQ-013 busy / done / error  output  1 each  session status.
REQ-014 cycle_count  output  32  number of RUN cycles elapsed.

Function
REQ-015 The state machine SHALL have the states IDLE, LOAD, RUN, HALT and ERR.
REQ-016 In IDLE, HALT or ERR, start with 1 <= load_len <= IMEM_DEPTH SHALL enter LOAD next cycle, clear done, error, cycle_count and the write pointer, and latch load_len and cycle_limit.
REQ-017 start with load_len == 0 or load_len > IMEM_DEPTH SHALL enter ERR next cycle with error = 1.
REQ-018 start SHALL be ignored in LOAD and RUN.
REQ-019 s_ready SHALL be 1 only in LOAD; a word transfers when s_valid and s_ready are both 1.
REQ-020 On each payload transfer, imem_we SHALL be 1 in the same cycle (combinational), imem_addr SHALL equal the write pointer, imem_wdata SHALL equal s_data, and the pointer SHALL increment.
REQ-021 imem_we SHALL be 0 in every cycle without a payload transfer.
REQ-022 After transfer number load_len, LOAD SHALL exit on the next edge, to RUN or per REQ-032.
REQ-023 core_rst SHALL be 0 only in RUN and 1 in every other state, so the core always starts from PC 0 after a complete load.
REQ-024 In RUN, cycle_count SHALL increment by 1 each cycle, wrapping modulo 2**32.
REQ-025 In RUN, core_instr == 32'h00100073 (EBREAK) SHALL enter HALT next cycle with done = 1.
REQ-026 In RUN with cycle_limit != 0, cycle_count == cycle_limit - 1 SHALL enter ERR next cycle with error = 1.
REQ-027 If REQ-025 and REQ-026 hold in the same cycle, EBREAK SHALL win (HALT).
REQ-028 busy SHALL be 1 in LOAD and RUN; done SHALL be 1 only in HALT; error SHALL be 1 only in ERR.
REQ-029 cycle_count SHALL hold its value in HALT and ERR until the next accepted start.

Reset
REQ-030 reset SHALL force, on the next edge: state IDLE; core_rst 1; s_ready, imem_we, busy, done and error 0; cycle_count 0; write pointer 0.
REQ-031 reset SHALL take priority over every other input, including during LOAD or RUN; a partial load SHALL be discarded.

Configuration
REQ-032 With BOOT_CHECKSUM_EN defined:
- after load_len payload words, LOAD SHALL accept one further trailer word with imem_we = 0.
- the 32-bit modular sum of the payload plus the trailer == 0 SHALL enter RUN; any other value SHALL enter ERR.
REQ-033 Without BOOT_CHECKSUM_EN, no trailer word SHALL be accepted, and LOAD SHALL enter RUN directly after the last payload word.

Verification
REQ-034 A bench SHALL cover the following directed scenarios:
- Basic load and run: load_len=3, words 0x00500093, 0x00100073, 0x00000013, stimulus at full rate -> imem writes to addresses 0, 1, 2; core_rst falls for RUN; core_instr = 0x00100073 in the 2nd RUN cycle -> done = 1, cycle_count = 2.
- Timeout: cycle_limit=10, EBREAK never presented -> error = 1 after exactly 10 RUN cycles, cycle_count = 10.
- Illegal length: start with load_len=0 and with load_len=257 -> ERR next cycle, imem_we never asserted.
- Stream stalls: s_valid low on alternating cycles during LOAD -> no write while s_valid is low, addresses contiguous.
- Reset mid-operation: reset in the 2nd LOAD cycle and again mid-RUN -> IDLE, core_rst = 1, all outputs at reset values.
- Checksum (BOOT_CHECKSUM_EN): payload 0x1 and 0x2 with trailer 0xFFFFFFFD -> RUN; the same payload with trailer 0x0 -> ERR, core_rst stays 1.

Source files
------------

// File: rtl/riscv_boot_ctrl.sv
// Boot controller: streams a program into imem, then runs the core until EBREAK or timeout.
// Optional trailer checksum on the stream: define BOOT_CHECKSUM_EN.
module riscv_boot_ctrl #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [31:0]       cycle_limit,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    input  logic [31:0]       core_instr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_HALT, S_ERR
    } state_t;

    localparam logic [ADDR_W:0] DEPTH  = (ADDR_W+1)'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);
    localparam logic [31:0]     EBREAK = 32'h0010_0073;

    state_t          state, nxt;
    logic [ADDR_W:0] wptr, len_q;
    logic [31:0]     limit_q, cnt_q;
    logic            in_load, xfer, payload, go, bad_len;

    assign in_load = (state == S_LOAD);
    assign xfer    = s_valid && in_load;
    // wptr == len_q only happens while waiting for the checksum trailer
    assign payload = xfer && (wptr != len_q);
    assign bad_len = (load_len == '0) || (load_len > DEPTH);
    assign go      = start && (state inside {S_IDLE, S_HALT, S_ERR});

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum_q, sum_fin;
    assign sum_fin = sum_q + s_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE, S_HALT, S_ERR: begin
                if (start) nxt = bad_len ? S_ERR : S_LOAD;
            end
            S_LOAD: begin
`ifdef BOOT_CHECKSUM_EN
                if (xfer && wptr == len_q)
                    nxt = (sum_fin == 32'd0) ? S_RUN : S_ERR;
`else
                if (xfer && wptr == len_q - ONE)
                    nxt = S_RUN;
`endif
            end
            S_RUN: begin
                // EBREAK outranks a simultaneous timeout
                if (core_instr == EBREAK)
                    nxt = S_HALT;
                else if (limit_q != 32'd0 && cnt_q == limit_q - 32'd1)
                    nxt = S_ERR;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr    <= '0;
            len_q   <= '0;
            limit_q <= '0;
            cnt_q   <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            if (go && !bad_len) begin
                wptr    <= '0;
                len_q   <= load_len;
                limit_q <= cycle_limit;
                cnt_q   <= '0;
`ifdef BOOT_CHECKSUM_EN
                sum_q   <= '0;
`endif
            end else if (payload) begin
                wptr  <= wptr + ONE;
`ifdef BOOT_CHECKSUM_EN
                sum_q <= sum_fin;
`endif
            end
            if (state == S_RUN) cnt_q <= cnt_q + 32'd1;
        end
    end

    always_comb begin
        s_ready     = in_load;
        imem_we     = payload;
        imem_addr   = wptr[ADDR_W-1:0];
        imem_wdata  = s_data;
        core_rst    = (state != S_RUN);
        busy        = in_load || (state == S_RUN);
        done        = (state == S_HALT);
        error       = (state == S_ERR);
        cycle_count = cnt_q;
    end

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Scoreboard bench for riscv_boot_ctrl: directed scenarios plus randomized sessions.
// Expected imem writes and session outcomes are queued by stimulus, popped by a monitor.
module tb_riscv_boot_ctrl;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start, s_valid, s_ready, imem_we, core_rst;
    logic          busy, done, error;
    logic [AW:0]   load_len;
    logic [31:0]   cycle_limit, s_data, imem_wdata, core_instr, cycle_count;
    logic [AW-1:0] imem_addr;

    typedef struct packed {
        logic        err;
        logic [31:0] cnt;
    } res_t;

    logic [AW+31:0] wq[$];
    res_t           rq[$];
    logic [31:0]    payload[$];
    int             cmp = 0;
    int             bad = 0;
    logic           endprev = 1'b0;

    riscv_boot_ctrl #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_len(load_len), .cycle_limit(cycle_limit),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .core_instr(core_instr),
        .busy(busy), .done(done), .error(error), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every imem write and every session end is matched to the queues
    always @(negedge clk) begin
        logic [AW+31:0] w;
        res_t           r;
        logic           endnow;
        if (imem_we === 1'b1) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                w = wq.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(w[AW+31:32]));
                chk("write_data", imem_wdata, w[31:0]);
            end
        end
        endnow = done | error;
        if (endnow && !endprev) begin
            if (rq.size() == 0) begin
                chk("unexpected_end", {30'd0, done, error}, 32'd0);
            end else begin
                r = rq.pop_front();
                chk("end_error", 32'(error), 32'(r.err));
                chk("end_done", 32'(done), 32'(!r.err));
                chk("end_count", cycle_count, r.cnt);
            end
        end
        endprev = endnow;
    end

    task automatic do_reset();
        start   = 1'b0;
        s_valid = 1'b0;
        reset   = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wq.delete();
        rq.delete();
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_count", cycle_count, 32'd0);
    endtask

    // k: RUN cycle (1-based) presenting EBREAK, 0 = never
    task automatic session(input int len, input logic [31:0] lim, input int k,
                           input bit stall, input int rst_load, input int rst_run,
                           input logic [31:0] adj);
        logic [31:0] sum, trailer;
        bit          legal, ckok, v;
        res_t        r;
        int          total, i, cyc, j;
        legal = (len >= 1) && (len <= DEPTH);
        if (!legal) do_reset();
        sum = 32'd0;
        for (int n = 0; n < len && n < payload.size(); n++) sum += payload[n];
        trailer = 32'd0 - sum + adj;
        ckok = !CK || (adj == 32'd0);
        if (!legal || !ckok) begin
            r.err = 1'b1; r.cnt = 32'd0;
        end else if (k != 0 && (lim == 0 || 32'(k) <= lim)) begin
            r.err = 1'b0; r.cnt = 32'(k);
        end else begin
            r.err = 1'b1; r.cnt = lim;
        end
        if (rst_load == 0 && rst_run == 0) rq.push_back(r);

        start = 1'b1;
        load_len = (AW+1)'(len);
        cycle_limit = lim;
        @(posedge clk); #1;
        start = 1'b0;
        load_len = $urandom;
        cycle_limit = $urandom;
        if (legal) begin
            chk("load_busy", 32'(busy), 32'd1);
            chk("load_core_rst", 32'(core_rst), 32'd1);
            total = len + (CK ? 1 : 0);
            i = 0;
            cyc = 0;
            while (i < total) begin
                cyc++;
                if (cyc > 4 * total + 10) begin
                    chk("load_timeout", 32'(i), 32'(total));
                    do_reset();
                    return;
                end
                if (cyc == rst_load) begin
                    do_reset();
                    return;
                end
                v = stall ? cyc[0] : 1'b1;
                s_valid = v;
                s_data = (i < len) ? payload[i] : trailer;
                if (v && s_ready) begin
                    if (i < len) wq.push_back({AW'(i), payload[i]});
                    i++;
                end
                @(posedge clk); #1;
            end
            s_valid = 1'b0;
            s_data = $urandom;
        end

        j = 0;
        for (int b = 0; b < 300; b++) begin
            if (done || error) break;
            if (!core_rst) begin
                j++;
                if (j == 1) chk("run_busy", 32'(busy), 32'd1);
                if (j == rst_run) begin
                    do_reset();
                    return;
                end
                core_instr = (j == k) ? EBREAK : 32'h0000_0013;
            end
            @(posedge clk); #1;
        end
        core_instr = 32'h0000_0013;
        if (!(done || error)) begin
            chk("end_timeout", {30'd0, done, error}, 32'd1);
            do_reset();
            return;
        end
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic rand_payload(input int len);
        payload.delete();
        for (int n = 0; n < len; n++) payload.push_back($urandom);
    endtask

    initial begin
        int len, k;
        logic [31:0] lim;
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        load_len = '0; cycle_limit = '0; core_instr = 32'h0000_0013;
        @(posedge clk); #1;
        do_reset();

        payload = '{32'h0050_0093, 32'h0010_0073, 32'h0000_0013};
        session(3, 32'd0, 2, 1'b0, 0, 0, 32'd0);
        rand_payload(2);
        session(2, 32'd10, 0, 1'b0, 0, 0, 32'd0);
        rand_payload(2);
        session(2, 32'd5, 5, 1'b0, 0, 0, 32'd0);
        session(0, 32'd0, 1, 1'b0, 0, 0, 32'd0);
        session(257, 32'd0, 1, 1'b0, 0, 0, 32'd0);
        rand_payload(5);
        session(5, 32'd0, 3, 1'b1, 0, 0, 32'd0);
        rand_payload(4);
        session(4, 32'd0, 3, 1'b0, 2, 0, 32'd0);
        rand_payload(3);
        session(3, 32'd0, 0, 1'b0, 0, 3, 32'd0);
        rand_payload(3);
        session(3, 32'd0, 1, 1'b0, 0, 0, 32'd0);
        rand_payload(DEPTH);
        session(DEPTH, 32'd0, 1, 1'b0, 0, 0, 32'd0);
`ifdef BOOT_CHECKSUM_EN
        payload = '{32'h1, 32'h2};
        session(2, 32'd0, 1, 1'b0, 0, 0, 32'd0);
        session(2, 32'd0, 1, 1'b0, 0, 0, 32'd3);
`endif
        for (int s = 0; s < 30; s++) begin
            len = (s % 10 == 9) ? (($urandom_range(0, 1) == 0) ? 0 : 257 + $urandom_range(0, 200))
                                : $urandom_range(1, 8);
            lim = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 15));
            k = $urandom_range(0, 15);
            if (lim == 0 && k == 0) k = 1;
            rand_payload(len > DEPTH ? 0 : len);
            session(len, lim, k, 1'($urandom_range(0, 1)), 0, 0,
                    ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom | 32'd1);
        end

        chk("writes_left", 32'(wq.size()), 32'd0);
        chk("ends_left", 32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
